// File: rtl/spi_flash_arbiter_if.sv
// Host-side request/response bundle shared by the 6809 port (0) and the boot/copy engine (1).
interface spi_flash_arbiter_if;
  logic        i_req0;
  logic        i_req1;
  logic        i_rw0;
  logic        i_rw1;
  logic [23:0] i_addr0;
  logic [23:0] i_addr1;
  logic [7:0]  i_wdata0;
  logic [7:0]  i_wdata1;
  logic        o_ack0;
  logic        o_ack1;
  logic [7:0]  o_rdata;
  logic        o_err;
  logic        o_busy;

  modport master (
    output i_req0, i_req1, i_rw0, i_rw1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    input  o_ack0, o_ack1, o_rdata, o_err, o_busy
  );

  modport slave (
    input  i_req0, i_req1, i_rw0, i_rw1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    output o_ack0, o_ack1, o_rdata, o_err, o_busy
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin arbiter owning one SPI flash in Mode 0 (SCK = clk/2).
// Reads are a single READ; writes are WREN, PAGE PROGRAM, then RDSR polling on WIP.
module spi_flash_arbiter #(
  parameter logic [15:0] POLL_LIMIT = 16'd48000,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic               clk,
  input  logic               reset,
  spi_flash_arbiter_if.slave bus,
  output logic               o_SPI_CLK,
  output logic               o_SPI_MOSI,
  output logic               o_SPI_CS,
  input  logic               i_SPI_MISO
);
  localparam int GW = $clog2(CS_GAP) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [3:0] {
    IDLE, RD_XFER, WREN_XFER, GAP1, PP_XFER, GAP2, POLL_XFER, POLL_GAP, DONE
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d, req_sel;
  logic          port_q, port_d;
  logic          last_q, last_d;
  logic [39:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]   poll_cnt_q, poll_cnt_d, poll_inc;
  logic          fail_q, fail_d;
  logic          cs_q, cs_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic          gnt0, gnt1, in_xfer, xfer_done, start;
  logic [39:0]   start_frame;
  logic [5:0]    start_bits;

  // On a tie the port that was not served last wins.
  assign gnt0     = bus.i_req0 & (~bus.i_req1 | last_q);
  assign gnt1     = bus.i_req1 & (~bus.i_req0 | ~last_q);
  assign req_sel  = gnt1 ? req_t'({bus.i_rw1, bus.i_addr1, bus.i_wdata1})
                         : req_t'({bus.i_rw0, bus.i_addr0, bus.i_wdata0});
  assign in_xfer  = (state_q == RD_XFER) || (state_q == WREN_XFER) ||
                    (state_q == PP_XFER) || (state_q == POLL_XFER);
  assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    port_d      = port_q;
    last_d      = last_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    fail_d      = fail_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    xfer_done   = 1'b0;
    start       = 1'b0;
    start_frame = '0;
    start_bits  = '0;

    // Shared bit engine: rising half samples MISO, falling half shifts MOSI
    // or, on the last bit, raises CS with SCK left low.
    if (in_xfer) begin
      if (!sck_q) begin
        sck_d = 1'b1;
        rx_d  = {rx_q[6:0], i_SPI_MISO};
      end else begin
        sck_d = 1'b0;
        if (bit_cnt_q == 6'd1) begin
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          xfer_done = 1'b1;
        end else begin
          tx_d      = {tx_q[38:0], 1'b0};
          mosi_d    = tx_q[38];
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          req_d      = req_sel;
          port_d     = gnt1;
          busy_d     = 1'b1;
          poll_cnt_d = '0;
          fail_d     = 1'b0;
          start      = 1'b1;
          if (req_sel.rw) begin
            start_frame = {CMD_READ, req_sel.addr, 8'h00};
            start_bits  = 6'd40;
            state_d     = RD_XFER;
          end else begin
            start_frame = {CMD_WREN, 32'h0};
            start_bits  = 6'd8;
            state_d     = WREN_XFER;
          end
        end
      end
      RD_XFER: if (xfer_done) state_d = DONE;
      WREN_XFER: begin
        if (xfer_done) begin
          gap_cnt_d = '0;
          state_d   = GAP1;
        end
      end
      GAP1: begin
        if (gap_cnt_q == GAP_LAST) begin
          start       = 1'b1;
          start_frame = {CMD_PP, req_q.addr, req_q.wdata};
          start_bits  = 6'd40;
          state_d     = PP_XFER;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      PP_XFER: begin
        if (xfer_done) begin
          gap_cnt_d = '0;
          state_d   = GAP2;
        end
      end
      GAP2, POLL_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          start       = 1'b1;
          start_frame = {CMD_RDSR, 32'h0};
          start_bits  = 6'd16;
          state_d     = POLL_XFER;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      POLL_XFER: begin
        // rx_q already holds the full status byte; WIP is its last bit.
        if (xfer_done) begin
          poll_cnt_d = poll_inc;
          if (rx_q[0] && (poll_cnt_q < POLL_LIMIT)) begin
            gap_cnt_d = '0;
            state_d   = POLL_GAP;
          end else begin
            fail_d  = rx_q[0];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        err_d   = fail_q;
        if (req_q.rw) rdata_d = rx_q;
        last_d  = port_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // CS falls with the frame MSB already on MOSI.
    if (start) begin
      tx_d      = start_frame;
      mosi_d    = start_frame[39];
      cs_d      = 1'b0;
      sck_d     = 1'b0;
      bit_cnt_d = start_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      port_q     <= 1'b0;
      last_q     <= 1'b1;
      tx_q       <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      fail_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      port_q     <= port_d;
      last_q     <= last_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      fail_q     <= fail_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_ack0  = ack0_q;
  assign bus.o_ack1  = ack1_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_err   = err_q;
  assign bus.o_busy  = busy_q;
  assign o_SPI_CLK   = sck_q;
  assign o_SPI_MOSI  = mosi_q;
  assign o_SPI_CS    = cs_q;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench: a behavioural SPI flash plus scoreboards for SPI frames and acks.
module tb_spi_flash_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic sck, mosi, cs, miso;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wip_cfg = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_arbiter_if bus ();

  spi_flash_arbiter #(.POLL_LIMIT(16'd4), .CS_GAP(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_SPI_CLK  (sck),
    .o_SPI_MOSI (mosi),
    .o_SPI_CS   (cs),
    .i_SPI_MISO (miso)
  );

  typedef struct { int nbits; logic [39:0] val; int gap; } xfer_t;
  typedef struct { logic port; logic err; logic [7:0] rdata; int lat; } ack_t;
  xfer_t xq[$];
  ack_t  aq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ 8'h86;
  endfunction

  task automatic exp_xfer(input int nb, input logic [39:0] v, input int g);
    xfer_t e;
    e.nbits = nb; e.val = v; e.gap = g;
    xq.push_back(e);
  endtask

  task automatic exp_ack(input logic p, input logic e, input logic [7:0] d, input int lat);
    ack_t a;
    a.port = p; a.err = e; a.rdata = d; a.lat = lat;
    aq.push_back(a);
  endtask

  task automatic exp_read(input logic [23:0] a);
    exp_xfer(40, {8'h03, a, 8'h00}, 0);
  endtask

  task automatic exp_write(input logic [23:0] a, input logic [7:0] d, input int polls);
    exp_xfer(8, 40'h06, 0);
    exp_xfer(40, {8'h02, a, d}, 2);
    for (int i = 0; i < polls; i++) exp_xfer(16, 40'h0500, 2);
  endtask

  task automatic wait_ack(input logic p, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (p ? bus.o_ack1 : bus.o_ack0) begin
        if (p) bus.i_req1 = 1'b0; else bus.i_req0 = 1'b0;
        return;
      end
    end
    check(p ? "ack1_timeout" : "ack0_timeout", 64'(bus.o_ack0 | bus.o_ack1), 1);
  endtask

  // Flash model and monitors, all evaluated on the falling clk edge.
  initial begin : flash_model
    logic prev_sck, prev_cs, in_txn, wip;
    logic [39:0] sh;
    logic [7:0]  cmd, st, d;
    logic [23:0] raddr;
    int nb, low, high, gap, polls, t0;
    xfer_t e;
    ack_t  a;
    prev_sck = 1'b0; prev_cs = 1'b1; in_txn = 1'b0; sh = '0; cmd = '0; raddr = '0;
    nb = 0; low = 0; high = 0; gap = 0; polls = 0; t0 = 0; miso = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) in_txn = 1'b0;
      if (!cs) begin
        if (prev_cs) begin
          if (!in_txn) begin in_txn = 1'b1; t0 = cyc; polls = 0; end
          gap = high; nb = 0; sh = '0; low = 0;
        end
        low++;
        if (sck && !prev_sck) begin
          sh = {sh[38:0], mosi};
          nb++;
          if (nb == 8) cmd = sh[7:0];
          if (nb == 32) raddr = sh[23:0];
        end
        if (!sck) begin
          wip = (wip_cfg < 0) || (polls < wip_cfg);
          st  = wip ? 8'h03 : 8'h00;
          d   = mem_byte(raddr);
          if (cmd == 8'h05 && nb >= 8 && nb < 16) miso = st[15-nb];
          else if (cmd == 8'h03 && nb >= 32 && nb < 40) miso = d[39-nb];
          else miso = 1'b0;
        end
      end else begin
        if (!prev_cs) begin
          check("spi_xfer_expected", 64'(xq.size() != 0), 1);
          if (xq.size() != 0) begin
            e = xq.pop_front();
            check("spi_bits", 64'(nb), 64'(e.nbits));
            check("spi_mosi", 64'(sh), 64'(e.val));
            check("spi_cs_low_cycles", 64'(low), 64'(2 * e.nbits));
            if (e.gap > 0) check("spi_cs_gap", 64'(gap), 64'(e.gap));
          end
          if (cmd == 8'h05 && nb == 16) polls++;
          high = 0;
        end
        high++;
        miso = 1'b0;
      end
      if (bus.o_ack0 || bus.o_ack1) begin
        check("ack_expected", 64'(aq.size() != 0), 1);
        if (aq.size() != 0) begin
          a = aq.pop_front();
          check("ack_port", 64'(bus.o_ack1), 64'(a.port));
          check("ack_both", 64'(bus.o_ack0 & bus.o_ack1), 0);
          check("ack_err", 64'(bus.o_err), 64'(a.err));
          check("ack_rdata", 64'(bus.o_rdata), 64'(a.rdata));
          check("ack_latency", 64'(cyc - t0), 64'(a.lat));
        end
        in_txn = 1'b0;
      end else begin
        check("err_without_ack", 64'(bus.o_err), 0);
      end
      prev_cs = cs; prev_sck = sck;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acks;
    logic [39:0] fr;
    reset = 1'b1;
    bus.i_req0 = 0; bus.i_req1 = 0; bus.i_rw0 = 0; bus.i_rw1 = 0;
    bus.i_addr0 = '0; bus.i_addr1 = '0; bus.i_wdata0 = '0; bus.i_wdata1 = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(cs), 1);
    check("rst_sck", 64'(sck), 0);
    check("rst_mosi", 64'(mosi), 0);
    check("rst_ack", 64'({bus.o_ack1, bus.o_ack0}), 0);
    check("rst_err", 64'(bus.o_err), 0);
    check("rst_busy", 64'(bus.o_busy), 0);
    check("rst_rdata", 64'(bus.o_rdata), 0);
    reset = 1'b0;

    // Port 0 read of 0x000123 -> 0xA5
    exp_read(24'h000123);
    exp_ack(1'b0, 1'b0, 8'hA5, 81);
    @(negedge clk);
    bus.i_req0 = 1; bus.i_rw0 = 1; bus.i_addr0 = 24'h000123;
    @(negedge clk);
    check("read_busy", 64'(bus.o_busy), 1);
    check("read_cs_low", 64'(cs), 0);
    wait_ack(1'b0, 200);
    @(negedge clk);
    check("rdata_held", 64'(bus.o_rdata), 64'hA5);
    check("ack0_one_cycle", 64'(bus.o_ack0), 0);

    // Port 1 write, WIP busy for 3 polls
    wip_cfg = 3;
    exp_write(24'h000FFF, 8'h3C, 4);
    exp_ack(1'b1, 1'b0, 8'hA5, 235);
    bus.i_req1 = 1; bus.i_rw1 = 0; bus.i_addr1 = 24'h000FFF; bus.i_wdata1 = 8'h3C;
    wait_ack(1'b1, 600);
    wip_cfg = 0;

    // Simultaneous reads after reset, held: grants alternate 0,1,0,1
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_read(24'h000010); exp_ack(1'b0, 1'b0, 8'h96, 81);
      exp_read(24'hABCDEF); exp_ack(1'b1, 1'b0, 8'h69, 81);
    end
    bus.i_req0 = 1; bus.i_rw0 = 1; bus.i_addr0 = 24'h000010;
    bus.i_req1 = 1; bus.i_rw1 = 1; bus.i_addr1 = 24'hABCDEF;
    acks = 0;
    for (int i = 0; i < 500 && acks < 4; i++) begin
      @(negedge clk);
      if (bus.o_ack0 || bus.o_ack1) acks++;
    end
    bus.i_req0 = 0; bus.i_req1 = 0;
    check("alternating_acks", 64'(acks), 4);

    // Write where WIP never clears: 5 polls then error
    wip_cfg = -1;
    exp_write(24'h000200, 8'h55, 5);
    exp_ack(1'b0, 1'b1, 8'h69, 269);
    bus.i_req0 = 1; bus.i_rw0 = 0; bus.i_addr0 = 24'h000200; bus.i_wdata0 = 8'h55;
    wait_ack(1'b0, 800);
    @(negedge clk);
    check("err_one_cycle", 64'(bus.o_err), 0);
    wip_cfg = 0;

    // Reset at E40 of a read, then reissue
    fr = {8'h03, 24'h000777, 8'h00};
    exp_xfer(20, fr >> 20, 0);
    bus.i_req1 = 1; bus.i_rw1 = 1; bus.i_addr1 = 24'h000777;
    repeat (40) @(negedge clk);
    reset = 1'b1; bus.i_req1 = 0;
    @(negedge clk);
    check("abort_cs", 64'(cs), 1);
    check("abort_sck", 64'(sck), 0);
    check("abort_mosi", 64'(mosi), 0);
    check("abort_ack", 64'({bus.o_ack1, bus.o_ack0}), 0);
    check("abort_busy", 64'(bus.o_busy), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    exp_read(24'h000777);
    exp_ack(1'b1, 1'b0, 8'hF1, 81);
    bus.i_req1 = 1;
    wait_ack(1'b1, 200);

    repeat (5) @(negedge clk);
    check("spi_queue_drained", 64'(xq.size()), 0);
    check("ack_queue_drained", 64'(aq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
